// File: rtl/syncfifo_gearbox.sv
// Synchronous FIFO with a width-converting front/back end.
// Upsize: a packer gathers narrow input slices into one wide word before it
// enters the main buffer. Downsize: wide stored words are read out slice by
// slice. With equal widths it is a plain synchronous FIFO.
// Each stored word carries its count of valid slices, which a partial
// upsize word needs.
module syncfifo_gearbox #(
  parameter int DIN_WIDTH  = 8,
  parameter int DOUT_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT_EN    = 1,
  parameter int MSB_FIFO   = 1,
  parameter int AFULL_TH   = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_TH  = 1,
  localparam int R  = (DOUT_WIDTH > DIN_WIDTH) ? DOUT_WIDTH / DIN_WIDTH
                                               : DIN_WIDTH / DOUT_WIDTH,
  localparam int SW = $clog2(R + 1),
  localparam int CW = ADDR_WIDTH + $clog2(R) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  wr_en,
  input  logic                  din_last,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [SW-1:0]         dout_slices,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [CW-1:0]         data_count
);

  localparam int  CAP  = 2 ** ADDR_WIDTH;
  localparam bit  UP   = DOUT_WIDTH > DIN_WIDTH;
  localparam bit  DN   = DIN_WIDTH > DOUT_WIDTH;
  localparam int  WW   = UP ? DOUT_WIDTH : DIN_WIDTH;
  localparam int  NW   = UP ? DIN_WIDTH : DOUT_WIDTH;
  localparam int  SELW = (R > 1) ? $clog2(R) : 1;

  logic [WW-1:0]         mem    [CAP];
  logic [SW-1:0]         sc_mem [CAP];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [SELW-1:0]       pk_cnt, rd_sel, pk_pos, rd_pos;
  logic [WW-1:0]         pk_data, wr_word, rd_word;
  logic [SW-1:0]         wr_sc, rd_sc, slices_q;
  logic [CW-1:0]         cnt, cnt_inc, cnt_dec;
  logic [DOUT_WIDTH-1:0] rd_slice, dout_q;
  logic                  wr_ok, rd_ok, pop, push, last_in, last_out;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign data_count   = cnt;
  assign almost_full  = (cnt >= CW'(AFULL_TH));
  assign almost_empty = (cnt <= CW'(AEMPTY_TH));

  // FWFT shows the head slice directly; otherwise the registered read result
  assign dout        = (FWFT_EN != 0) ? (empty ? '0 : rd_slice) : dout_q;
  assign dout_slices = (FWFT_EN != 0) ? (empty ? '0 : rd_sc) : slices_q;

  // Handshake qualification, slice placement and count deltas.
  // A read that frees a main-buffer slot lets a write through even when full,
  // so rd+wr at full keeps the buffer full.
  always_comb begin
    pk_pos   = (MSB_FIFO != 0) ? SELW'(R - 1) - pk_cnt : pk_cnt;
    rd_pos   = (MSB_FIFO != 0) ? SELW'(R - 1) - rd_sel : rd_sel;
    last_in  = !UP || (pk_cnt == SELW'(R - 1)) || din_last;
    last_out = !DN || (rd_sel == SELW'(R - 1));
    rd_ok    = rd_en && !empty;
    pop      = rd_ok && last_out;
    wr_ok    = wr_en && (!full || pop);
    push     = wr_ok && last_in;
    wr_word  = UP ? (pk_data | (WW'(din) << (pk_pos * NW))) : WW'(din);
    wr_sc    = UP ? SW'(pk_cnt) + SW'(1) : SW'(1);
    rd_word  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    rd_sc    = sc_mem[rd_ptr[ADDR_WIDTH-1:0]];
    rd_slice = DN ? DOUT_WIDTH'(rd_word >> (rd_pos * NW)) : DOUT_WIDTH'(rd_word);
    cnt_inc  = wr_ok ? CW'(DN ? R : 1) : '0;
    cnt_dec  = rd_ok ? (UP ? CW'(rd_sc) : CW'(1)) : '0;
  end

  // Storage array: contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]]    <= wr_word;
      sc_mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_sc;
    end
  end

  // Pointers, packer, unpacker, occupancy and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pk_data   <= '0;
      pk_cnt    <= '0;
      rd_sel    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (ADDR_WIDTH + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (ADDR_WIDTH + 1)'(1);
      if (UP && wr_ok) begin
        if (last_in) begin
          pk_data <= '0;
          pk_cnt  <= '0;
        end else begin
          pk_data <= wr_word;
          pk_cnt  <= pk_cnt + SELW'(1);
        end
      end
      if (DN && rd_ok) rd_sel <= last_out ? '0 : rd_sel + SELW'(1);
      cnt       <= cnt + cnt_inc - cnt_dec;
      overflow  <= wr_en && !wr_ok;
      underflow <= rd_en && empty;
    end
  end

  // Registered read port used when first-word-fall-through is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      slices_q <= '0;
    end else if (rd_ok) begin
      dout_q   <= rd_slice;
      slices_q <= rd_sc;
    end
  end

endmodule

// File: tb/tb_syncfifo_gearbox.sv
// Bench for syncfifo_gearbox: three instances (8->32 MSB-first, 8->24 MSB-first,
// 32->8 LSB-first). Expected read words are queued by the stimulus; monitors
// pop and compare on every accepted read.
module tb_syncfifo_gearbox;

  typedef struct {
    logic [31:0] d;
    int          s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_up[$];
  exp_t q_r3[$];
  exp_t q_dn[$];

  // 8 -> 32, MSB first
  logic [7:0]  up_din = '0;
  logic        up_wr_en = 1'b0, up_last = 1'b0, up_rd_en = 1'b0;
  logic        up_full, up_afull, up_ovf, up_empty, up_aempty, up_udf;
  logic [31:0] up_dout;
  logic [2:0]  up_sl;
  logic [6:0]  up_cnt;

  // 8 -> 24, MSB first
  logic [7:0]  r3_din = '0;
  logic        r3_wr_en = 1'b0, r3_last = 1'b0, r3_rd_en = 1'b0;
  logic        r3_full, r3_afull, r3_ovf, r3_empty, r3_aempty, r3_udf;
  logic [23:0] r3_dout;
  logic [1:0]  r3_sl;
  logic [6:0]  r3_cnt;

  // 32 -> 8, LSB first
  logic [31:0] dn_din = '0;
  logic        dn_wr_en = 1'b0, dn_last = 1'b0, dn_rd_en = 1'b0;
  logic        dn_full, dn_afull, dn_ovf, dn_empty, dn_aempty, dn_udf;
  logic [7:0]  dn_dout;
  logic [2:0]  dn_sl;
  logic [6:0]  dn_cnt;

  syncfifo_gearbox #(.DIN_WIDTH(8), .DOUT_WIDTH(32), .ADDR_WIDTH(4), .FWFT_EN(1), .MSB_FIFO(1)) u_up (
    .clk(clk), .rst_n(rst_n), .din(up_din), .wr_en(up_wr_en), .din_last(up_last),
    .full(up_full), .almost_full(up_afull), .overflow(up_ovf), .dout(up_dout),
    .dout_slices(up_sl), .rd_en(up_rd_en), .empty(up_empty), .almost_empty(up_aempty),
    .underflow(up_udf), .data_count(up_cnt));

  syncfifo_gearbox #(.DIN_WIDTH(8), .DOUT_WIDTH(24), .ADDR_WIDTH(4), .FWFT_EN(1), .MSB_FIFO(1)) u_r3 (
    .clk(clk), .rst_n(rst_n), .din(r3_din), .wr_en(r3_wr_en), .din_last(r3_last),
    .full(r3_full), .almost_full(r3_afull), .overflow(r3_ovf), .dout(r3_dout),
    .dout_slices(r3_sl), .rd_en(r3_rd_en), .empty(r3_empty), .almost_empty(r3_aempty),
    .underflow(r3_udf), .data_count(r3_cnt));

  syncfifo_gearbox #(.DIN_WIDTH(32), .DOUT_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(1), .MSB_FIFO(0)) u_dn (
    .clk(clk), .rst_n(rst_n), .din(dn_din), .wr_en(dn_wr_en), .din_last(dn_last),
    .full(dn_full), .almost_full(dn_afull), .overflow(dn_ovf), .dout(dn_dout),
    .dout_slices(dn_sl), .rd_en(dn_rd_en), .empty(dn_empty), .almost_empty(dn_aempty),
    .underflow(dn_udf), .data_count(dn_cnt));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic up_wr(input logic [7:0] b, input logic last);
    up_din = b; up_last = last; up_wr_en = 1'b1;
    step();
    up_wr_en = 1'b0; up_last = 1'b0;
  endtask

  task automatic up_rd();
    up_rd_en = 1'b1;
    step();
    up_rd_en = 1'b0;
  endtask

  task automatic dn_rd();
    dn_rd_en = 1'b1;
    step();
    dn_rd_en = 1'b0;
  endtask

  // Monitors: compare on each accepted read (sampled on the falling edge)
  always @(negedge clk) begin
    if (rst_n && up_rd_en && !up_empty) begin
      if (q_up.size() == 0) begin
        check("up_unexpected_read", 64'(up_dout), 64'hDEAD);
      end else begin
        exp_t e;
        e = q_up.pop_front();
        check("up_dout", 64'(up_dout), 64'(e.d));
        check("up_dout_slices", 64'(up_sl), 64'(e.s));
      end
    end
    if (rst_n && r3_rd_en && !r3_empty) begin
      if (q_r3.size() == 0) begin
        check("r3_unexpected_read", 64'(r3_dout), 64'hDEAD);
      end else begin
        exp_t e;
        e = q_r3.pop_front();
        check("r3_dout", 64'(r3_dout), 64'(e.d));
        check("r3_dout_slices", 64'(r3_sl), 64'(e.s));
      end
    end
    if (rst_n && dn_rd_en && !dn_empty) begin
      if (q_dn.size() == 0) begin
        check("dn_unexpected_read", 64'(dn_dout), 64'hDEAD);
      end else begin
        exp_t e;
        e = q_dn.pop_front();
        check("dn_dout", 64'(dn_dout), 64'(e.d));
        check("dn_dout_slices", 64'(dn_sl), 64'(e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_empty", 64'(up_empty), 64'd1);
    check("rst_aempty", 64'(up_aempty), 64'd1);
    check("rst_full", 64'(up_full), 64'd0);
    check("rst_afull", 64'(up_afull), 64'd0);
    check("rst_dout", 64'(up_dout), 64'd0);
    check("rst_slices", 64'(up_sl), 64'd0);
    check("rst_count", 64'(up_cnt), 64'd0);
    check("rst_ovf_udf", {62'd0, up_ovf, up_udf}, 64'd0);
    check("rst_dn_empty", 64'(dn_empty), 64'd1);
    rst_n = 1'b1;
    step();

    // Upsize full word
    up_wr(8'h11, 1'b0); up_wr(8'h22, 1'b0); up_wr(8'h33, 1'b0);
    check("up_3slices_empty", 64'(up_empty), 64'd1);
    check("up_3slices_count", 64'(up_cnt), 64'd3);
    q_up.push_back('{32'h11223344, 4});
    up_wr(8'h44, 1'b0);
    check("up_word_empty", 64'(up_empty), 64'd0);
    check("up_word_count", 64'(up_cnt), 64'd4);
    up_rd();
    check("up_after_rd_empty", 64'(up_empty), 64'd1);
    check("up_after_rd_count", 64'(up_cnt), 64'd0);

    // R=3 partial word via din_last
    r3_din = 8'hAA; r3_wr_en = 1'b1; step();
    r3_din = 8'hBB; r3_last = 1'b1; q_r3.push_back('{32'h00AABB00, 2}); step();
    r3_wr_en = 1'b0; r3_last = 1'b0;
    check("r3_empty", 64'(r3_empty), 64'd0);
    check("r3_count", 64'(r3_cnt), 64'd2);
    r3_rd_en = 1'b1; step(); r3_rd_en = 1'b0;
    check("r3_after_rd_empty", 64'(r3_empty), 64'd1);

    // Downsize, LSB slice first
    dn_din = 32'h44332211; dn_wr_en = 1'b1; step(); dn_wr_en = 1'b0;
    q_dn.push_back('{32'h11, 1}); q_dn.push_back('{32'h22, 1});
    q_dn.push_back('{32'h33, 1}); q_dn.push_back('{32'h44, 1});
    check("dn_count4", 64'(dn_cnt), 64'd4);
    dn_rd();
    check("dn_count3", 64'(dn_cnt), 64'd3);
    check("dn_not_empty", 64'(dn_empty), 64'd0);
    dn_rd(); dn_rd(); dn_rd();
    check("dn_empty", 64'(dn_empty), 64'd1);
    check("dn_count0", 64'(dn_cnt), 64'd0);

    // Underflow
    up_rd();
    check("udf_pulse", 64'(up_udf), 64'd1);
    check("udf_count", 64'(up_cnt), 64'd0);
    step();
    check("udf_clear", 64'(up_udf), 64'd0);

    // Almost-empty boundary with packer content
    up_wr(8'h01, 1'b0);
    check("ae_count1", 64'(up_cnt), 64'd1);
    check("ae_at1", 64'(up_aempty), 64'd1);
    check("ae_empty_pk", 64'(up_empty), 64'd1);
    q_up.push_back('{32'h01020000, 2});
    up_wr(8'h02, 1'b1);
    check("ae_count2", 64'(up_cnt), 64'd2);
    check("ae_at2", 64'(up_aempty), 64'd0);
    up_rd();

    // Fill to full
    for (int k = 0; k < 16; k++) begin
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++) begin
        w = {w[23:0], 8'(4 * k + j)};
        up_wr(8'(4 * k + j), 1'b0);
      end
      q_up.push_back('{w, 4});
    end
    check("fill_full", 64'(up_full), 64'd1);
    check("fill_afull", 64'(up_afull), 64'd1);
    check("fill_count", 64'(up_cnt), 64'd64);
    up_wr(8'hEE, 1'b0);
    check("ovf_pulse", 64'(up_ovf), 64'd1);
    check("ovf_count", 64'(up_cnt), 64'd64);
    step();
    check("ovf_clear", 64'(up_ovf), 64'd0);

    // Simultaneous read + write at full
    up_din = 8'h5A; up_last = 1'b1; up_wr_en = 1'b1; up_rd_en = 1'b1;
    q_up.push_back('{32'h5A000000, 1});
    step();
    up_wr_en = 1'b0; up_last = 1'b0; up_rd_en = 1'b0;
    check("rdwr_full", 64'(up_full), 64'd1);
    check("rdwr_ovf", 64'(up_ovf), 64'd0);
    check("rdwr_count", 64'(up_cnt), 64'd61);
    up_rd_en = 1'b1;
    repeat (16) step();
    up_rd_en = 1'b0;
    check("drain_empty", 64'(up_empty), 64'd1);
    check("drain_count", 64'(up_cnt), 64'd0);
    check("drain_afull", 64'(up_afull), 64'd0);

    // Asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) begin
      dn_din = 32'hA0A1A2A3 + 32'(k); dn_wr_en = 1'b1; step();
    end
    dn_wr_en = 1'b0;
    up_wr(8'h91, 1'b0); up_wr(8'h92, 1'b0); up_wr(8'h93, 1'b0);
    check("pre_rst_dn_count", 64'(dn_cnt), 64'd12);
    check("pre_rst_up_count", 64'(up_cnt), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dn_empty", 64'(dn_empty), 64'd1);
    check("arst_dn_count", 64'(dn_cnt), 64'd0);
    check("arst_up_count", 64'(up_cnt), 64'd0);
    check("arst_dn_dout", 64'(dn_dout), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Packer restarts at slice 0 after reset
    q_up.push_back('{32'hC1C2C3C4, 4});
    up_wr(8'hC1, 1'b0); up_wr(8'hC2, 1'b0); up_wr(8'hC3, 1'b0); up_wr(8'hC4, 1'b0);
    check("post_rst_count", 64'(up_cnt), 64'd4);
    up_rd();
    step();

    check("q_up_drained", 64'(q_up.size()), 64'd0);
    check("q_r3_drained", 64'(q_r3.size()), 64'd0);
    check("q_dn_drained", 64'(q_dn.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
